// File: rtl/test_sequencer.sv
// test_sequencer: runs N_TESTS test blocks one after another, with a timeout on each, and records which passed.
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   go           starts the whole sequence; only sampled in IDLE or DONE
//   finish       per-test finish levels; only the bit of the running test counts
//   start        one-hot start level for the running test
//   busy, done   high in WAIT/GAP and in DONE respectively
//   cur_idx      index of the test currently or last addressed
//   pass_mask    tests that finished before their timeout
//   timeout_mask tests that timed out
//   all_pass     done with every pass_mask bit set
//   cycles       WAIT cycles elapsed for the current test
module test_sequencer #(
    parameter int N_TESTS = 4,
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic [N_TESTS-1:0] finish,
    output logic [N_TESTS-1:0] start,
    output logic               busy,
    output logic               done,
    output logic [3:0]         cur_idx,
    output logic [N_TESTS-1:0] pass_mask,
    output logic [N_TESTS-1:0] timeout_mask,
    output logic               all_pass,
    output logic [CNT_W-1:0]   cycles
);
    typedef enum logic [1:0] {IDLE, WAIT, GAP, DONE} state_t;
    localparam logic [N_TESTS-1:0] ONE  = N_TESTS'(1);
    localparam logic [3:0]         LAST = 4'(N_TESTS - 1);
    localparam logic [CNT_W-1:0]   TLIM = CNT_W'(TIMEOUT - 1);
    state_t             state, state_n;
    logic [N_TESTS-1:0] start_n, pass_n, tmo_n;
    logic [3:0]         idx_n;
    logic [CNT_W-1:0]   cyc_n;
    logic               busy_n, done_n, ap_n, hit;
    // start is one-hot at cur_idx while in WAIT, so masking finish with it picks out only the running test
    assign hit = |(finish & start);
    always_comb begin
        state_n = state;
        start_n = start;
        idx_n   = cur_idx;
        pass_n  = pass_mask;
        tmo_n   = timeout_mask;
        cyc_n   = cycles;
        if ((state == IDLE || state == DONE) && go) begin
            state_n = WAIT;
            start_n = ONE;
            idx_n   = '0;
            cyc_n   = '0;
            pass_n  = '0;
            tmo_n   = '0;
        end else if (state == WAIT) begin
            if (hit || cycles == TLIM) begin
                state_n = GAP;
                start_n = '0;
                pass_n  = pass_mask | (hit ? start : '0);
                tmo_n   = timeout_mask | (hit ? '0 : start);
            end else begin
                cyc_n = cycles + 1'b1;
            end
        end else if (state == GAP) begin
            if (cur_idx == LAST) begin
                state_n = DONE;
            end else begin
                state_n = WAIT;
                idx_n   = cur_idx + 4'd1;
                cyc_n   = '0;
                start_n = ONE << idx_n;
            end
        end
        busy_n = state_n == WAIT || state_n == GAP;
        done_n = state_n == DONE;
        ap_n   = done_n && &pass_n;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            start        <= '0;
            cur_idx      <= '0;
            pass_mask    <= '0;
            timeout_mask <= '0;
            cycles       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            all_pass     <= 1'b0;
        end else begin
            state        <= state_n;
            start        <= start_n;
            cur_idx      <= idx_n;
            pass_mask    <= pass_n;
            timeout_mask <= tmo_n;
            cycles       <= cyc_n;
            busy         <= busy_n;
            done         <= done_n;
            all_pass     <= ap_n;
        end
    end
endmodule

// File: tb/tb_test_sequencer.sv
// tb_test_sequencer: directed self-checking bench for test_sequencer (N_TESTS=4, TIMEOUT=8).
module tb_test_sequencer;
    logic        clk, rst, go;
    logic [3:0]  finish, start, cur_idx, pass_mask, timeout_mask;
    logic        busy, done, all_pass;
    logic [15:0] cycles;
    logic [3:0]  exp_pass, exp_tmo;
    int          checks, errors;
    test_sequencer #(.N_TESTS(4), .TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .go(go), .finish(finish), .start(start),
        .busy(busy), .done(done), .cur_idx(cur_idx), .pass_mask(pass_mask),
        .timeout_mask(timeout_mask), .all_pass(all_pass), .cycles(cycles)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic tick();
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic go_start();
        go = 1'b1;
        tick();
        go = 1'b0;
        exp_pass = 4'b0000;
        exp_tmo  = 4'b0000;
        chk("go_start", start, 4'b0001);
        chk("go_busy", busy, 1);
        chk("go_done", done, 0);
        chk("go_pass_clr", pass_mask, 4'b0000);
        chk("go_tmo_clr", timeout_mask, 4'b0000);
    endtask
    // Serve test i: hold WAIT for d edges, then raise finish[i] (or let it time out when to=1, d=7).
    // noise drives other finish bits; pg pulses go during WAIT.
    task automatic serve(input int i, input int d, input logic [3:0] noise, input bit to, input bit pg);
        logic [3:0] oh;
        oh = 4'b0001 << i;
        chk("w_start", start, oh);
        chk("w_cyc0", cycles, 0);
        chk("w_idx", cur_idx, i);
        finish = noise & ~oh;
        for (int c = 0; c < d; c++) begin
            go = pg && c == 1;
            tick();
            go = 1'b0;
        end
        chk("w_cyc", cycles, d);
        chk("w_hold", start, oh);
        chk("w_idx_hold", cur_idx, i);
        if (!to) finish = finish | oh;
        tick();
        finish = 4'b0000;
        if (to) exp_tmo = exp_tmo | oh;
        else exp_pass = exp_pass | oh;
        chk("g_start", start, 0);
        chk("g_busy", busy, 1);
        chk("g_pass", pass_mask, exp_pass);
        chk("g_tmo", timeout_mask, exp_tmo);
        chk("g_cyc", cycles, d);
        tick();
    endtask
    task automatic chk_done(input logic ap);
        chk("d_done", done, 1);
        chk("d_busy", busy, 0);
        chk("d_start", start, 0);
        chk("d_idx", cur_idx, 3);
        chk("d_pass", pass_mask, exp_pass);
        chk("d_tmo", timeout_mask, exp_tmo);
        chk("d_allpass", all_pass, ap);
    endtask
    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        go = 1'b0;
        finish = 4'b0000;
        exp_pass = 4'b0000;
        exp_tmo = 4'b0000;
        #1;
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", cur_idx, 0);
        chk("rst_cyc", cycles, 0);
        chk("rst_allpass", all_pass, 0);
        tick();
        tick();
        rst = 1'b1;
        go_start();
        serve(0, 5, 4'b1000, 0, 0);
        serve(1, 5, 4'b0000, 0, 0);
        serve(2, 5, 4'b0000, 0, 0);
        serve(3, 5, 4'b0000, 0, 0);
        chk_done(1'b1);
        tick();
        tick();
        chk_done(1'b1);
        go_start();
        serve(0, 2, 4'b0000, 0, 0);
        serve(1, 7, 4'b0000, 0, 1);
        serve(2, 7, 4'b0000, 1, 0);
        serve(3, 1, 4'b0000, 0, 0);
        chk_done(1'b0);
        chk("ret_pass", pass_mask, 4'b1011);
        chk("ret_tmo", timeout_mask, 4'b0100);
        go_start();
        serve(0, 1, 4'b0000, 0, 0);
        chk("pre_rst_start", start, 4'b0010);
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("ar_start", start, 0);
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        chk("ar_idx", cur_idx, 0);
        chk("ar_pass", pass_mask, 0);
        chk("ar_tmo", timeout_mask, 0);
        chk("ar_cyc", cycles, 0);
        chk("ar_allpass", all_pass, 0);
        tick();
        rst = 1'b1;
        go_start();
        chk("rs_idx", cur_idx, 0);
        serve(0, 3, 4'b0000, 0, 0);
        chk("rs_next", start, 4'b0010);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
